serial_alu: RTL
===============

// Module: serial_alu
// PURPOSE
//  Parametrised bit-serial ALU; successor to the 4-bit serial NAND/ADD/OR/SUB unit.
//  Processes one operand bit per clock, LSB first, over WIDTH cycles, with a start/done handshake.
//  Adds carry/borrow chaining (ADC/SBB), XOR and a signed-overflow flag, and holds its result until the next start.
//  Sits between the operand register file and the flag/writeback stage of the datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2); one bit processed per cycle
//  CNT_W  $clog2(WIDTH)  localparam; width of the bit counter, not overridable
// PORTS
//  clk     in   1      single clock; all state updates on posedge
//  rst_n   in   1      synchronous reset, active-low, sampled on posedge clk
//  start   in   1      request; accepted only when busy==0
//  opcode  in   3      operation; sampled with start
//  a       in   WIDTH  operand A; sampled with start
//  b       in   WIDTH  operand B; sampled with start
//  busy    out  1      high from the cycle after accept until done
//  done    out  1      one-cycle pulse; result and flags valid from this cycle onward
//  result  out  WIDTH  registered result; held until the next accepted start
//  zf      out  1      result==0
//  sf      out  1      result[WIDTH-1]
//  cf      out  1      carry out (ADD/ADC) or borrow (SUB/SBB); 0 for logic ops
//  of      out  1      signed overflow (ADD/ADC/SUB/SBB); 0 for logic ops
// BEHAVIOUR
//  Reset: rst_n==0 at a posedge forces state=IDLE, counter=0, busy=0, done=0, result=0, zf=1, sf=0, cf=0, of=0.
//  Mid-operation reset aborts the operation: no done pulse, and the partial result is discarded.
//  Opcodes: 000 CLR, 001 NAND, 010 ADD, 011 OR, 100 SUB (a-b), 101 XOR, 110 ADC (a+b+cf), 111 SBB (a-b-cf).
//  FSM IDLE -> RUN: start && !busy. Latch a, b and opcode into shift regs; carry_in = 0 (ADD), 1 (SUB), cf (ADC), ~cf (SBB).
//  FSM IDLE -> DONE: start with opcode CLR. No serial pass; result=0, zf=1, sf=cf=of=0.
//  FSM RUN: each cycle computes bit i = f(a_sr[0], b_sr[0]^sub, carry), shifts it into the result MSB, shifts the operands right and increments the counter.
//  FSM RUN -> DONE: after the bit WIDTH-1 cycle. Subtraction uses ~b plus carry; the borrow flag is cf = ~carry_out.
//  FSM DONE: done=1 for exactly one cycle; result, zf, sf, cf and of update together on entry; then -> IDLE.
//  Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH+1 (CLR: after edge k+1).
//  Flags change only on done; they are never updated mid-operation.
//  of = carry into MSB XOR carry out of MSB.
//  start while busy or done is ignored (no queuing). start is accepted in IDLE on the cycle right after done.
//  Operand inputs may change freely after the accept edge.
//  ADC/SBB use the cf value held from the previous completed op (0 after reset).
//  Carry wraps modulo 2^WIDTH; the carry out appears only in cf.
// STRUCTURE
//  Package serial_alu_pkg: opcode localparams (OP_CLR..OP_SBB) and FSM state encoding (S_IDLE, S_RUN, S_DONE).
//  Sub-module serial_alu_bitcell (combinational): inputs a_bit, b_bit, cin, op; outputs r_bit, cout.
//  Top-level: FSM, counter, shift registers, flag registers.
// TESTING (WIDTH=8 unless noted)
//  1 Reset: rst_n low 2 cycles -> result=0, zf=1, busy=0, done=0.
//    Start during reset -> ignored.
//  2 ADD a=8'hF0 b=8'h20 -> done 10 cycles after start, result=8'h10, cf=1, of=0, zf=0, sf=0.
//    Then ADC a=0 b=0 -> result=8'h01, cf=0.
//  3 SUB a=8'h05 b=8'h07 -> result=8'hFE, cf=1 (borrow), sf=1.
//    SUB a=8'h80 b=8'h01 -> result=8'h7F, of=1, cf=0.
//  4 Logic: NAND 8'hFF/8'h0F -> 8'hF0; OR 8'hA0/8'h05 -> 8'hA5; XOR 8'hAA/8'hAA -> 8'h00, zf=1; cf=of=0 for all three.
//  5 Protocol: start held high through a run -> exactly one done.
//    Second start mid-run with new operands -> ignored; result reflects the first operands.
//    Back-to-back start right after done -> accepted.
//  6 rst_n low at bit 3 of an ADD -> no done pulse, outputs at reset values.
//    CLR -> done after 1 cycle, result=0.
//    Rerun test 2 with WIDTH=4 and WIDTH=16.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM states and opcode helpers.
package serial_alu_pkg;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_SBB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic op_is_arith(input logic [2:0] op);
        return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB};
    endfunction

    function automatic logic op_is_sub(input logic [2:0] op);
        return op inside {OP_SUB, OP_SBB};
    endfunction

    // Subtraction runs as a + ~b + cin, so a clear borrow means cin = 1.
    function automatic logic carry_init(input logic [2:0] op, input logic cf_prev);
        case (op)
            OP_SUB:  return 1'b1;
            OP_ADC:  return cf_prev;
            OP_SBB:  return ~cf_prev;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serial_alu_bitcell.sv
// One-bit ALU slice; the caller pre-inverts b_bit for subtraction.
module serial_alu_bitcell
    import serial_alu_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r_bit,
    output logic       cout
);

    always_comb begin
        r_bit = 1'b0;
        cout  = 1'b0;
        case (op)
            OP_NAND: r_bit = ~(a_bit & b_bit);
            OP_OR:   r_bit = a_bit | b_bit;
            OP_XOR:  r_bit = a_bit ^ b_bit;
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                r_bit = a_bit ^ b_bit ^ cin;
                cout  = (a_bit & b_bit) | (cin & (a_bit ^ b_bit));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU, LSB first, one bit per clock, start/done handshake.
// Result and flags are committed together when the done pulse is raised.
//
//  state  | meaning
//  S_IDLE | waiting for start (ignored while done is high)
//  S_RUN  | shifting one operand bit per cycle through the bitcell
//  S_DONE | commit result/flags; done pulses on the following cycle
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             cf,
    output logic             of
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [2:0]       op_q;
    logic             carry;
    logic             pend_cf, pend_of;
    logic             accept, last_bit;
    logic             r_bit, cout;

    serial_alu_bitcell u_cell (
        .a_bit (a_sr[0]),
        .b_bit (b_sr[0] ^ op_is_sub(op_q)),
        .cin   (carry),
        .op    (op_q),
        .r_bit (r_bit),
        .cout  (cout)
    );

    assign busy     = (state != S_IDLE);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    accept    = 1'b1;
                    state_nxt = (opcode == OP_CLR) ? S_DONE : S_RUN;
                end
            end
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            op_q    <= OP_CLR;
            carry   <= 1'b0;
            pend_cf <= 1'b0;
            pend_of <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zf      <= 1'b1;
            sf      <= 1'b0;
            cf      <= 1'b0;
            of      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == S_DONE);
            if (accept) begin
                a_sr    <= a;
                b_sr    <= b;
                op_q    <= opcode;
                carry   <= carry_init(opcode, cf);
                cnt     <= '0;
                res_sr  <= '0;
                pend_cf <= 1'b0;
                pend_of <= 1'b0;
            end else if (state == S_RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {r_bit, res_sr[WIDTH-1:1]};
                carry  <= cout;
                cnt    <= cnt + CNT_W'(1);
                // On the MSB cycle, carry holds the carry into the MSB.
                if (last_bit && op_is_arith(op_q)) begin
                    pend_cf <= cout ^ op_is_sub(op_q);
                    pend_of <= carry ^ cout;
                end
            end
            if (state == S_DONE) begin
                result <= res_sr;
                zf     <= (res_sr == '0);
                sf     <= res_sr[WIDTH-1];
                cf     <= pend_cf;
                of     <= pend_of;
            end
        end
    end

endmodule
